tile_scroll_scheduler: RTL

- Sequences the Piano Tapper playfield: holds 4-lane x ROWS tile occupancy, resolves player taps against the bottom row, and scrolls the field one row per step request.
- After every scroll it sequences a full-grid repaint through the shared VGA plot port (RX/RY/colour/plot).
- It sits between the tempo ratedivider (step), the key edge detectors (tap), the row pattern source (new_row) and the VGA adapter.

---
 rtl/tile_scroll_scheduler.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/tile_scroll_scheduler.sv
// rtl/tile_scroll_scheduler.sv - Piano Tapper playfield: tap resolution, row scrolling and full-grid repaint sequencing
module tile_scroll_scheduler #(
  parameter int         ROWS       = 8,
  parameter int         TILE       = 10,
  parameter int         LANE_PITCH = 12,
  parameter int         ROW_PITCH  = 12,
  parameter logic [7:0] X0         = 8'd20,
  parameter logic [6:0] Y0         = 7'd10
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       step,
  input  logic [3:0] new_row,
  input  logic [3:0] tap,
  output logic       busy,
  output logic       plot,
  output logic [7:0] RX,
  output logic [6:0] RY,
  output logic [1:0] colour,
  output logic [7:0] score,
  output logic       game_over
);
  localparam int PW = (TILE > 1) ? $clog2(TILE) : 1;
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [2:0] {IDLE, CHECK, SHIFT, DRAW, DONE} state_t;
  state_t state, state_next;

  logic [3:0]    grid [ROWS];
  logic [3:0]    held_row, pending_row;
  logic          pending, frozen;
  logic [PW-1:0] px, py;
  logic [1:0]    lane;
  logic [RW-1:0] row;

  logic [3:0] bottom, hits, misses;
  logic [2:0] hit_count;
  logic [8:0] score_sum;
  logic       tap_live, accept, end_game, last_pixel;

  assign bottom     = grid[ROWS-1];
  assign tap_live   = (state == IDLE) && !game_over;
  assign hits       = tap_live ? (tap & bottom) : 4'b0;
  assign misses     = tap_live ? (tap & ~bottom) : 4'b0;
  assign hit_count  = 3'(hits[0]) + 3'(hits[1]) + 3'(hits[2]) + 3'(hits[3]);
  assign score_sum  = 9'(score) + 9'(hit_count);
  // frozen marks that the final game-over repaint has been committed
  assign accept     = (state == IDLE) && !frozen && (step || pending);
  assign end_game   = game_over || (|bottom);
  assign last_pixel = (px == PW'(TILE-1)) && (py == PW'(TILE-1)) &&
                      (lane == 2'd3) && (row == RW'(ROWS-1));
  assign busy       = (state != IDLE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CHECK;
      CHECK:   state_next = end_game ? DRAW : SHIFT;
      SHIFT:   state_next = DRAW;
      DRAW:    if (last_pixel) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < ROWS; r++) grid[r] <= 4'b0;
      held_row    <= 4'b0;
      pending_row <= 4'b0;
      pending     <= 1'b0;
      frozen      <= 1'b0;
      px          <= '0;
      py          <= '0;
      lane        <= 2'd0;
      row         <= '0;
      plot        <= 1'b0;
      RX          <= 8'd0;
      RY          <= 7'd0;
      colour      <= 2'b00;
      score       <= 8'd0;
      game_over   <= 1'b0;
    end else begin
      plot <= (state == DRAW);
      if (state == DRAW) begin
        RX     <= X0 + 8'(int'(lane) * LANE_PITCH) + 8'(px);
        RY     <= Y0 + 7'(int'(row) * ROW_PITCH) + 7'(py);
        colour <= grid[row][lane] ? (game_over ? 2'b11 : 2'b01) : 2'b00;
        if (px == PW'(TILE-1)) begin
          px <= '0;
          if (py == PW'(TILE-1)) begin
            py   <= '0;
            lane <= lane + 2'd1;
            if (lane == 2'd3) row <= row + RW'(1);
          end else begin
            py <= py + PW'(1);
          end
        end else begin
          px <= px + PW'(1);
        end
      end else begin
        px   <= '0;
        py   <= '0;
        lane <= 2'd0;
        row  <= '0;
      end

      if (tap_live) begin
        grid[ROWS-1] <= bottom & ~tap;
        score        <= (score_sum > 9'd255) ? 8'd255 : score_sum[7:0];
        if (|misses) game_over <= 1'b1;
      end

      if (accept) begin
        pending  <= 1'b0;
        held_row <= pending ? pending_row : new_row;
      end else if (busy && step && !frozen && !pending) begin
        pending     <= 1'b1;
        pending_row <= new_row;
      end

      // Missed tile or earlier loss: last repaint, nothing queued after it
      if (state == CHECK && end_game) begin
        game_over <= 1'b1;
        frozen    <= 1'b1;
        pending   <= 1'b0;
      end

      if (state == SHIFT) begin
        for (int r = ROWS-1; r > 0; r--) grid[r] <= grid[r-1];
        grid[0] <= held_row;
      end
    end
  end
endmodule
